// File: rtl/bin_peak_hold_pkg.sv
// Shared widths, defaults and FSM encoding for the bin peak-hold stage.
package bin_peak_hold_pkg;

    localparam int unsigned DEF_IN_W         = 10;
    localparam int unsigned DEF_OUT_W        = 10;
    localparam int unsigned DEF_BINS         = 32;
    localparam int unsigned DEF_ADDR_W       = 5;
    localparam int unsigned DEF_SHIFT        = 8;
    localparam int unsigned DEF_DECAY_FRAMES = 4;
    localparam int unsigned DEF_DECAY_STEP   = 1;

    typedef enum logic [1:0] {
        StRun,
        StDrain,
        StSweep
    } state_e;

endpackage

// File: rtl/bin_mag_sq.sv
// Two-stage squared magnitude: S1 squares, S2 sums, shifts and saturates.
module bin_mag_sq
    import bin_peak_hold_pkg::*;
#(
    parameter int unsigned IN_W   = DEF_IN_W,
    parameter int unsigned OUT_W  = DEF_OUT_W,
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned SHIFT  = DEF_SHIFT
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     i_valid,
    input  logic signed [IN_W-1:0]   i_real,
    input  logic signed [IN_W-1:0]   i_imag,
    input  logic [ADDR_W-1:0]        i_addr,
    output logic                     o_valid,
    output logic [ADDR_W-1:0]        o_addr,
    output logic [OUT_W-1:0]         o_mag,
    output logic                     o_busy
);

    localparam int unsigned PROD_W = 2 * IN_W;
    localparam int unsigned SUM_W  = PROD_W + 1;
    localparam logic [OUT_W-1:0] MAG_MAX = '1;

    logic signed [PROD_W-1:0] w_re_ext;
    logic signed [PROD_W-1:0] w_im_ext;
    logic [SUM_W-1:0]         w_sum;
    logic [SUM_W-1:0]         w_shifted;
    logic [OUT_W-1:0]         w_mag;

    logic                     r_s1_valid;
    logic [ADDR_W-1:0]        r_s1_addr;
    logic [PROD_W-1:0]        r_re_sq;
    logic [PROD_W-1:0]        r_im_sq;
    logic                     r_s2_valid;
    logic [ADDR_W-1:0]        r_s2_addr;
    logic [OUT_W-1:0]         r_s2_mag;

    assign w_re_ext = {{IN_W{i_real[IN_W-1]}}, i_real};
    assign w_im_ext = {{IN_W{i_imag[IN_W-1]}}, i_imag};

    // Squares are non-negative, so the sum is treated as unsigned with one carry bit.
    assign w_sum     = {1'b0, r_re_sq} + {1'b0, r_im_sq};
    assign w_shifted = w_sum >> SHIFT;
    assign w_mag     = (|w_shifted[SUM_W-1:OUT_W]) ? MAG_MAX : w_shifted[OUT_W-1:0];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_s1_valid <= 1'b0;
            r_s1_addr  <= '0;
            r_re_sq    <= '0;
            r_im_sq    <= '0;
            r_s2_valid <= 1'b0;
            r_s2_addr  <= '0;
            r_s2_mag   <= '0;
        end else begin
            r_s1_valid <= i_valid;
            r_s1_addr  <= i_addr;
            r_re_sq    <= w_re_ext * w_re_ext;
            r_im_sq    <= w_im_ext * w_im_ext;
            r_s2_valid <= r_s1_valid;
            r_s2_addr  <= r_s1_addr;
            r_s2_mag   <= w_mag;
        end
    end

    assign o_valid = r_s2_valid;
    assign o_addr  = r_s2_addr;
    assign o_mag   = r_s2_mag;
    assign o_busy  = r_s1_valid | r_s2_valid;

endmodule

// File: rtl/bin_peak_hold.sv
// Per-bin peak hold with periodic decay sweep, driving the frequency BRAM write port.
module bin_peak_hold
    import bin_peak_hold_pkg::*;
#(
    parameter int unsigned IN_W         = DEF_IN_W,
    parameter int unsigned OUT_W        = DEF_OUT_W,
    parameter int unsigned BINS         = DEF_BINS,
    parameter int unsigned ADDR_W       = DEF_ADDR_W,
    parameter int unsigned SHIFT        = DEF_SHIFT,
    parameter int unsigned DECAY_FRAMES = DEF_DECAY_FRAMES,
    parameter int unsigned DECAY_STEP   = DEF_DECAY_STEP
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [IN_W-1:0]   in_real,
    input  logic signed [IN_W-1:0]   in_imag,
    input  logic [ADDR_W-1:0]        in_addr,
    input  logic                     frame_tick,
    output logic                     w_en,
    output logic [ADDR_W-1:0]        w_addr,
    output logic [OUT_W-1:0]         w_data
);

    localparam int unsigned CNT_W = (DECAY_FRAMES > 1) ? $clog2(DECAY_FRAMES) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DECAY_FRAMES - 1);
    localparam logic [ADDR_W-1:0] IDX_LAST = ADDR_W'(BINS - 1);
    localparam logic [OUT_W-1:0]  STEP     = OUT_W'(DECAY_STEP);

    state_e              r_state;
    state_e              w_state_d;
    logic                r_in_ready;
    logic                r_pending;
    logic                w_pending_d;
    logic                r_rearm;
    logic                w_rearm_d;
    logic [CNT_W-1:0]    r_cnt;
    logic [ADDR_W-1:0]   r_idx;
    logic [OUT_W-1:0]    r_peak [BINS];
    logic                r_w_en;
    logic [ADDR_W-1:0]   r_w_addr;
    logic [OUT_W-1:0]    r_w_data;

    logic                w_addr_ok;
    logic                w_accept;
    logic                w_wrap;
    logic                w_sweep_done;
    logic                w_pipe_empty;
    logic                w_s2_valid;
    logic [ADDR_W-1:0]   w_s2_addr;
    logic [OUT_W-1:0]    w_s2_mag;
    logic                w_mag_busy;
    logic [OUT_W-1:0]    w_rmw_peak;
    logic [OUT_W-1:0]    w_rmw_new;
    logic [OUT_W-1:0]    w_dec_peak;
    logic [OUT_W-1:0]    w_dec_new;

    if (BINS < (1 << ADDR_W)) begin : g_addr_chk
        assign w_addr_ok = (32'(in_addr) < BINS);
    end else begin : g_addr_full
        assign w_addr_ok = 1'b1;
    end

    assign w_accept     = in_valid && r_in_ready && w_addr_ok;
    assign w_wrap       = frame_tick && (r_cnt == CNT_LAST);
    assign w_sweep_done = (r_state == StSweep) && (r_idx == IDX_LAST);
    assign w_pipe_empty = !w_mag_busy && !w_s2_valid && !r_w_en;

    bin_mag_sq #(
        .IN_W   (IN_W),
        .OUT_W  (OUT_W),
        .ADDR_W (ADDR_W),
        .SHIFT  (SHIFT)
    ) u_mag_sq (
        .clk     (clk),
        .reset_n (reset_n),
        .i_valid (w_accept),
        .i_real  (in_real),
        .i_imag  (in_imag),
        .i_addr  (in_addr),
        .o_valid (w_s2_valid),
        .o_addr  (w_s2_addr),
        .o_mag   (w_s2_mag),
        .o_busy  (w_mag_busy)
    );

    assign w_rmw_peak = r_peak[w_s2_addr];
    assign w_rmw_new  = (w_s2_mag > w_rmw_peak) ? w_s2_mag : w_rmw_peak;
    assign w_dec_peak = r_peak[r_idx];
    assign w_dec_new  = (w_dec_peak > STEP) ? (w_dec_peak - STEP) : '0;

    always_comb begin
        w_state_d = r_state;
        unique case (r_state)
            StRun:   if (r_pending) w_state_d = StDrain;
            StDrain: if (w_pipe_empty) w_state_d = StSweep;
            StSweep: if (w_sweep_done) w_state_d = StRun;
            default: w_state_d = StRun;
        endcase
    end

    // A wrap during a sweep re-arms pending so the next sweep follows immediately.
    always_comb begin
        w_pending_d = r_pending;
        w_rearm_d   = r_rearm;
        if (w_sweep_done) begin
            w_pending_d = r_rearm;
            w_rearm_d   = 1'b0;
        end else if ((r_state == StSweep) && w_wrap) begin
            w_rearm_d = 1'b1;
        end
        if (w_wrap) w_pending_d = 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= StRun;
            r_in_ready <= 1'b0;
            r_pending  <= 1'b0;
            r_rearm    <= 1'b0;
            r_cnt      <= '0;
            r_idx      <= '0;
        end else begin
            r_state    <= w_state_d;
            r_in_ready <= (w_state_d == StRun);
            r_pending  <= w_pending_d;
            r_rearm    <= w_rearm_d;
            if (frame_tick) r_cnt <= w_wrap ? '0 : (r_cnt + CNT_W'(1));
            if (w_sweep_done) r_idx <= '0;
            else if (r_state == StSweep) r_idx <= r_idx + ADDR_W'(1);
        end
    end

    // Pipeline writes and sweep writes never coincide: the sweep only starts once S1..S3 drain.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < BINS; i++) r_peak[i] <= '0;
            r_w_en   <= 1'b0;
            r_w_addr <= '0;
            r_w_data <= '0;
        end else begin
            r_w_en <= 1'b0;
            if (w_s2_valid) begin
                r_peak[w_s2_addr] <= w_rmw_new;
                r_w_en            <= 1'b1;
                r_w_addr          <= w_s2_addr;
                r_w_data          <= w_rmw_new;
            end else if (r_state == StSweep) begin
                r_peak[r_idx] <= w_dec_new;
                r_w_en        <= 1'b1;
                r_w_addr      <= r_idx;
                r_w_data      <= w_dec_new;
            end
        end
    end

    assign in_ready = r_in_ready;
    assign w_en     = r_w_en;
    assign w_addr   = r_w_addr;
    assign w_data   = r_w_data;

endmodule
